// File: rtl/riscv_pkg.sv
// Shared encodings for the ID/EX stage: ALU opcodes, forward-select codes, ctrl bit positions.
package riscv_pkg;
  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_COMP = 4'b1000
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // ctrl = {regwrite, memread, memwrite, memtoreg}
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;
endpackage

// File: rtl/fwd_mux.sv
// One-operand RAW bypass: EX/MEM beats MEM/WB, x0 is never bypassed.
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src,
  input  logic [XLEN-1:0] reg_data,
  input  logic            mem_regwrite,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_regwrite,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] fwd_data,
  output fwd_sel_e        sel
);
  always_comb begin
    sel = FWD_REG;
    if (src != '0) begin
      if (mem_regwrite && mem_rd == src)     sel = FWD_MEM;
      else if (wb_regwrite && wb_rd == src)  sel = FWD_WB;
    end
    case (sel)
      FWD_MEM: fwd_data = mem_result;
      FWD_WB:  fwd_data = wb_result;
      default: fwd_data = reg_data;
    endcase
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion and flush.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [RA_W-1:0]  id_rs1_addr,
  input  logic [RA_W-1:0]  id_rs2_addr,
  input  logic [RA_W-1:0]  id_rd_addr,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [3:0]       id_alucontrol,
  input  logic             id_alusrc,
  input  logic [3:0]       id_ctrl,
  input  logic             flush,
  input  logic             ex_ready,
  input  logic             mem_regwrite,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic [XLEN-1:0]  mem_result,
  input  logic             wb_regwrite,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic [XLEN-1:0]  wb_result,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_in1,
  output logic [XLEN-1:0]  ex_in2,
  output logic [XLEN-1:0]  ex_inimm,
  output logic             ex_alusrc,
  output logic [3:0]       ex_alucontrol,
  output logic [3:0]       ex_ctrl,
  output logic [RA_W-1:0]  ex_rd,
  output logic [CNT_W-1:0] stall_cnt
);
  // index 0 = rs1, index 1 = rs2
  logic [1:0][RA_W-1:0] rs_addr;
  logic [1:0][XLEN-1:0] rs_data;
  logic [1:0][XLEN-1:0] fwd;
  logic [1:0][RA_W-1:0] id_rs_addr;
  logic [1:0][XLEN-1:0] id_rs_data;
  fwd_sel_e             sel [2];
  logic                 load_use;

  assign id_rs_addr = {id_rs2_addr, id_rs1_addr};
  assign id_rs_data = {id_rs2_data, id_rs1_data};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd (
      .src          (rs_addr[g]),
      .reg_data     (rs_data[g]),
      .mem_regwrite (mem_regwrite),
      .mem_rd       (mem_rd),
      .mem_result   (mem_result),
      .wb_regwrite  (wb_regwrite),
      .wb_rd        (wb_rd),
      .wb_result    (wb_result),
      .fwd_data     (fwd[g]),
      .sel          (sel[g])
    );
  end

  assign ex_in1 = fwd[0];
  assign ex_in2 = fwd[1];

  // rs2 only matters when the ALU actually reads the register path
  assign load_use = ex_valid && ex_ctrl[CTRL_MEMREAD] && (ex_rd != '0) && id_valid &&
                    ((ex_rd == id_rs1_addr) || ((ex_rd == id_rs2_addr) && !id_alusrc));
  assign id_ready = flush || (ex_ready && !load_use);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      rs_addr       <= '0;
      rs_data       <= '0;
      ex_inimm      <= '0;
      ex_alusrc     <= 1'b0;
      ex_alucontrol <= 4'b0000;
      ex_ctrl       <= '0;
      ex_rd         <= '0;
      stall_cnt     <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (!ex_ready) begin
      // Capture any producer seen during the hold so it survives its retirement
      for (int i = 0; i < 2; i++)
        if (sel[i] != FWD_REG) rs_data[i] <= fwd[i];
    end else if (load_use) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end else if (id_valid) begin
      ex_valid      <= 1'b1;
      rs_addr       <= id_rs_addr;
      rs_data       <= id_rs_data;
      ex_inimm      <= id_imm;
      ex_alusrc     <= id_alusrc;
      ex_alucontrol <= id_alucontrol;
      ex_ctrl       <= id_ctrl;
      ex_rd         <= id_rd_addr;
    end else begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, load-use, hold refresh, flush, saturation.
module tb_id_ex_stage;
  localparam int XLEN = 32, RA_W = 5, CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid, id_ready;
  logic [RA_W-1:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [XLEN-1:0]  id_rs1_data, id_rs2_data, id_imm;
  logic [3:0]       id_alucontrol, id_ctrl;
  logic             id_alusrc, flush, ex_ready;
  logic             mem_regwrite, wb_regwrite;
  logic [RA_W-1:0]  mem_rd, wb_rd;
  logic [XLEN-1:0]  mem_result, wb_result;
  logic             ex_valid, ex_alusrc;
  logic [XLEN-1:0]  ex_in1, ex_in2, ex_inimm;
  logic [3:0]       ex_alucontrol, ex_ctrl;
  logic [RA_W-1:0]  ex_rd;
  logic [CNT_W-1:0] stall_cnt;

  int nvec = 0, nerr = 0;
  int exp_cnt;

  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alucontrol(id_alucontrol), .id_alusrc(id_alusrc), .id_ctrl(id_ctrl),
    .flush(flush), .ex_ready(ex_ready),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_inimm(ex_inimm),
    .ex_alusrc(ex_alusrc), .ex_alucontrol(ex_alucontrol), .ex_ctrl(ex_ctrl),
    .ex_rd(ex_rd), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [3:0] alu, input logic src, input logic [3:0] ctl);
    id_valid = 1'b1; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_alucontrol = alu; id_alusrc = src; id_ctrl = ctl;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    mem_regwrite = 1'b0; mem_rd = '0; mem_result = '0;
    wb_regwrite = 1'b0; wb_rd = '0; wb_result = '0;
    issue(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 4'b0010, 1'b0, 4'b1000);

    // reset with decode valid: everything stays 0
    tick(); tick();
    chk("rst_valid", ex_valid, 0);
    chk("rst_in1", ex_in1, 0);
    chk("rst_in2", ex_in2, 0);
    chk("rst_imm", ex_inimm, 0);
    chk("rst_alusrc", ex_alusrc, 0);
    chk("rst_aluctl", ex_alucontrol, 0);
    chk("rst_ctrl", ex_ctrl, 0);
    chk("rst_rd", ex_rd, 0);
    chk("rst_cnt", stall_cnt, 0);

    rst_n = 1'b1; #1;
    chk("first_ready", id_ready, 1);
    tick();
    chk("first_valid", ex_valid, 1);
    chk("first_in1", ex_in1, 32'h11);
    chk("first_in2", ex_in2, 32'h22);
    chk("first_imm", ex_inimm, 32'h33);
    chk("first_aluctl", ex_alucontrol, 4'b0010);
    chk("first_ctrl", ex_ctrl, 4'b1000);
    chk("first_rd", ex_rd, 3);

    // forwarding priority on rs1=5
    issue(5'd5, 5'd6, 5'd8, 32'h1, 32'h2, 32'h0, 4'b0010, 1'b0, 4'b1000);
    tick();
    id_valid = 1'b0;
    mem_regwrite = 1'b1; mem_rd = 5'd5; mem_result = 32'h10;
    wb_regwrite = 1'b1; wb_rd = 5'd5; wb_result = 32'h20; #1;
    chk("fwd_mem_prio", ex_in1, 32'h10);
    chk("fwd_rs2_none", ex_in2, 32'h2);
    mem_regwrite = 1'b0; #1;
    chk("fwd_wb", ex_in1, 32'h20);
    wb_regwrite = 1'b0; #1;
    chk("fwd_reg", ex_in1, 32'h1);

    // x0 is never forwarded
    issue(5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 4'b0001, 1'b0, 4'b1000);
    tick();
    id_valid = 1'b0;
    mem_regwrite = 1'b1; mem_rd = 5'd0; mem_result = 32'hFF;
    wb_regwrite = 1'b1; wb_rd = 5'd0; wb_result = 32'hEE; #1;
    chk("x0_in1", ex_in1, 0);
    chk("x0_in2", ex_in2, 0);
    mem_regwrite = 1'b0; wb_regwrite = 1'b0;
    tick();

    // load-use: lw x3, then add x4,x3,x1
    issue(5'd2, 5'd0, 5'd3, 32'h100, 32'h0, 32'h4, 4'b0010, 1'b1, 4'b1101);
    tick();
    issue(5'd3, 5'd1, 5'd4, 32'h333, 32'h111, 32'h0, 4'b0010, 1'b0, 4'b1000); #1;
    chk("lu_ready", id_ready, 0);
    chk("lu_cnt0", stall_cnt, 0);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_ctrl", ex_ctrl, 0);
    chk("lu_cnt1", stall_cnt, 1);
    chk("lu_ready_after", id_ready, 1);
    tick();
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_rd", ex_rd, 4);
    chk("lu_add_ctrl", ex_ctrl, 4'b1000);
    chk("lu_add_in1", ex_in1, 32'h333);
    chk("lu_cnt_hold", stall_cnt, 1);

    // load-use boundaries: rs2 with alusrc=1, no id_valid, rd=0
    issue(5'd2, 5'd0, 5'd3, 32'h100, 32'h0, 32'h4, 4'b0010, 1'b1, 4'b1101);
    tick();
    issue(5'd1, 5'd3, 5'd4, 32'h0, 32'h0, 32'h8, 4'b0010, 1'b1, 4'b1000); #1;
    chk("lu_rs2_imm", id_ready, 1);
    id_alusrc = 1'b0; #1;
    chk("lu_rs2_reg", id_ready, 0);
    id_valid = 1'b0; #1;
    chk("lu_no_idvalid", id_ready, 1);
    tick();
    issue(5'd2, 5'd0, 5'd0, 32'h100, 32'h0, 32'h4, 4'b0010, 1'b1, 4'b1101);
    tick();
    issue(5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 4'b1000); #1;
    chk("lu_rd0", id_ready, 1);
    id_valid = 1'b0;
    tick();

    // EX hold while WB retires x7; refresh keeps the value
    issue(5'd0, 5'd7, 5'd9, 32'h0, 32'h5, 32'h0, 4'b0110, 1'b0, 4'b1000);
    tick();
    issue(5'd0, 5'd8, 5'd10, 32'h0, 32'h6, 32'h0, 4'b0000, 1'b0, 4'b1000);
    ex_ready = 1'b0;
    wb_regwrite = 1'b1; wb_rd = 5'd7; wb_result = 32'hABCD; #1;
    chk("hold_ready", id_ready, 0);
    chk("hold_fwd", ex_in2, 32'hABCD);
    tick();
    wb_regwrite = 1'b0;
    tick(); tick();
    ex_ready = 1'b1; id_valid = 1'b0; #1;
    chk("hold_in2", ex_in2, 32'hABCD);
    chk("hold_rd", ex_rd, 9);
    chk("hold_aluctl", ex_alucontrol, 4'b0110);
    chk("hold_valid", ex_valid, 1);
    tick();

    // flush beats both load_use and !ex_ready
    issue(5'd2, 5'd0, 5'd3, 32'h100, 32'h0, 32'h4, 4'b0010, 1'b1, 4'b1101);
    tick();
    issue(5'd3, 5'd1, 5'd4, 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 4'b1000);
    ex_ready = 1'b0; flush = 1'b1; #1;
    chk("flush_ready", id_ready, 1);
    tick();
    flush = 1'b0; ex_ready = 1'b1; id_valid = 1'b0; #1;
    chk("flush_valid", ex_valid, 0);
    chk("flush_ctrl", ex_ctrl, 0);
    chk("flush_cnt", stall_cnt, 1);
    chk("flush_ready_after", id_ready, 1);
    tick();

    // stall counter saturates at all-ones
    exp_cnt = 1;
    for (int i = 0; i < 3; i++) begin
      issue(5'd2, 5'd0, 5'd3, 32'h100, 32'h0, 32'h4, 4'b0010, 1'b1, 4'b1101);
      tick();
      issue(5'd3, 5'd1, 5'd4, 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 4'b1000);
      tick();
      exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
      chk($sformatf("sat_cnt%0d", i), stall_cnt, exp_cnt);
    end
    id_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
